// File: rtl/control_flow_unit.sv
// Registered control-flow decoder: jumps, calls/returns, halt and stack-memory strobes.
// Optional return-address stack is enabled by defining CFU_RAS_EN.
module control_flow_unit #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  instr,
    input  logic [DATA_W-1:0]            f_reg,
    input  logic [DATA_W-1:0]            t_reg,
    input  logic [23:0]                  imm,
    input  logic [ADDR_W-1:0]            pc,
    input  logic                         resume,
    input  logic                         clr_fault,
    output logic                         redirect,
    output logic [ADDR_W-1:0]            target,
    output logic                         push_o,
    output logic                         pop_o,
    output logic                         gsa_o,
    output logic                         switch_o,
    output logic [DATA_W-1:0]            mem_arg,
    output logic                         halted,
    output logic                         ras_ovf,
    output logic                         ras_unf,
    output logic [$clog2(RAS_DEPTH):0]   ras_level
);
    localparam int LVL_W = $clog2(RAS_DEPTH) + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [4:0] OP_JMP    = 5'b00001;
    localparam logic [4:0] OP_JMPI   = 5'b01001;
    localparam logic [4:0] OP_JMPFI  = 5'b01010;
    localparam logic [4:0] OP_JMPBI  = 5'b01011;
    localparam logic [4:0] OP_JMPC   = 5'b00101;
    localparam logic [4:0] OP_JMPCI  = 5'b01101;
    localparam logic [4:0] OP_JMPCFI = 5'b01110;
    localparam logic [4:0] OP_JMPCBI = 5'b01111;
    localparam logic [4:0] OP_CALL   = 5'b10000;
    localparam logic [4:0] OP_CALLI  = 5'b10001;
    localparam logic [4:0] OP_RET    = 5'b10010;
    localparam logic [4:0] OP_HALT   = 5'b11000;
    localparam logic [4:0] OP_PUSH   = 5'b11001;
    localparam logic [4:0] OP_POP    = 5'b11010;
    localparam logic [4:0] OP_GSA    = 5'b11011;
    localparam logic [4:0] OP_SWITCH = 5'b11100;

    logic [0:0]        state_q, state_d;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              push_q, push_d, pop_q, pop_d, gsa_q, gsa_d, switch_q, switch_d;
    logic [DATA_W-1:0] mem_arg_q, mem_arg_d;

    logic              accept, cond;
    logic [4:0]        opc;
    logic [ADDR_W+15:0] imm_wide;
    logic [ADDR_W-1:0] imm_a, f_a;
    logic              unused_instr_bits;

    assign accept   = in_valid && (state_q == ST_RUN);
    assign opc      = instr[28:24];
    assign cond     = |t_reg;
    assign imm_wide = {{ADDR_W{1'b0}}, imm[15:0]};
    assign imm_a    = imm_wide[ADDR_W-1:0];
    assign f_a      = f_reg[ADDR_W-1:0];
    assign unused_instr_bits = ^{instr[31:29], instr[15:0]};

`ifdef CFU_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              do_push, do_pop, ras_empty, ras_full;
    logic [ADDR_W-1:0] ras_top, pc_inc;

    assign do_push   = accept && ((opc == OP_CALL) || (opc == OP_CALLI));
    assign do_pop    = accept && (opc == OP_RET);
    assign ras_empty = (level_q == '0);
    assign ras_full  = (level_q == LVL_W'(RAS_DEPTH));
    assign ras_top   = ras_mem[ptr_q - PTR_W'(1)];
    assign pc_inc    = pc + ADDR_W'(1);

    // Circular stack: pushing when full wraps onto the oldest slot.
    always_comb begin
        ptr_d   = ptr_q;
        level_d = level_q;
        ovf_d   = ovf_q & ~clr_fault;
        unf_d   = unf_q & ~clr_fault;
        if (do_push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (ras_full) ovf_d = 1'b1;
            else          level_d = level_q + LVL_W'(1);
        end else if (do_pop) begin
            if (ras_empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d   = ptr_q - PTR_W'(1);
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) ras_mem[ptr_q] <= pc_inc;
    end

    assign ras_level = level_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;
`else
    assign ras_level = '0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        redirect_d = 1'b0;
        target_d   = target_q;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        gsa_d      = 1'b0;
        switch_d   = 1'b0;
        mem_arg_d  = mem_arg_q;
        if ((state_q == ST_HALT) && resume) state_d = ST_RUN;
        if (accept) begin
            case (opc)
                OP_JMP:    begin redirect_d = 1'b1; target_d = f_a; end
                OP_JMPI:   begin redirect_d = 1'b1; target_d = imm_a; end
                OP_JMPFI:  begin redirect_d = 1'b1; target_d = pc + imm_a; end
                OP_JMPBI:  begin redirect_d = 1'b1; target_d = pc - imm_a; end
                OP_JMPC:   if (cond) begin redirect_d = 1'b1; target_d = f_a; end
                OP_JMPCI:  if (cond) begin redirect_d = 1'b1; target_d = imm_a; end
                OP_JMPCFI: if (cond) begin redirect_d = 1'b1; target_d = pc + imm_a; end
                OP_JMPCBI: if (cond) begin redirect_d = 1'b1; target_d = pc - imm_a; end
                OP_CALL:   begin redirect_d = 1'b1; target_d = f_a; end
                OP_CALLI:  begin redirect_d = 1'b1; target_d = imm_a; end
                OP_RET: begin
                    redirect_d = 1'b1;
`ifdef CFU_RAS_EN
                    target_d = ras_empty ? f_a : ras_top;
`else
                    target_d = f_a;
`endif
                end
                OP_HALT:   begin redirect_d = 1'b1; target_d = pc; state_d = ST_HALT; end
                OP_PUSH:   begin push_d = 1'b1; mem_arg_d = f_reg; end
                OP_POP:    begin pop_d = 1'b1; mem_arg_d = {{(DATA_W-8){1'b0}}, instr[23:16]}; end
                OP_GSA:    begin gsa_d = 1'b1; mem_arg_d = {{(DATA_W-8){1'b0}}, instr[23:16]}; end
                OP_SWITCH: begin switch_d = 1'b1; mem_arg_d = {{(DATA_W-24){1'b0}}, imm}; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            redirect_q <= 1'b0;
            target_q   <= '0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            gsa_q      <= 1'b0;
            switch_q   <= 1'b0;
            mem_arg_q  <= '0;
        end else begin
            state_q    <= state_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            gsa_q      <= gsa_d;
            switch_q   <= switch_d;
            mem_arg_q  <= mem_arg_d;
        end
    end

    assign redirect = redirect_q;
    assign target   = target_q;
    assign push_o   = push_q;
    assign pop_o    = pop_q;
    assign gsa_o    = gsa_q;
    assign switch_o = switch_q;
    assign mem_arg  = mem_arg_q;
    assign halted   = (state_q == ST_HALT);
    assign in_ready = (state_q == ST_RUN);
endmodule

// File: tb/tb_control_flow_unit.sv
// Randomized and directed bench for control_flow_unit against a queue-based reference model.
module tb_control_flow_unit;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int D  = 8;
`ifdef CFU_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic          clk, rst_n, in_valid, in_ready, resume, clr_fault;
    logic [31:0]   instr;
    logic [DW-1:0] f_reg, t_reg, mem_arg;
    logic [23:0]   imm;
    logic [AW-1:0] pc, target;
    logic          redirect, push_o, pop_o, gsa_o, switch_o, halted, ras_ovf, ras_unf;
    logic [3:0]    ras_level;

    control_flow_unit #(.ADDR_W(AW), .DATA_W(DW), .RAS_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .f_reg(f_reg), .t_reg(t_reg), .imm(imm), .pc(pc),
        .resume(resume), .clr_fault(clr_fault), .redirect(redirect), .target(target),
        .push_o(push_o), .pop_o(pop_o), .gsa_o(gsa_o), .switch_o(switch_o),
        .mem_arg(mem_arg), .halted(halted), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
        .ras_level(ras_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model state
    logic          m_redirect, m_push, m_pop, m_gsa, m_switch, m_halted, m_ovf, m_unf;
    logic [15:0]   m_target;
    logic [31:0]   m_mem_arg;
    logic [15:0]   ras_q[$];

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [7:0] b);
        return {3'b101, op, b, 16'h5A5A};
    endfunction

    task automatic model_reset();
        m_redirect = 0; m_push = 0; m_pop = 0; m_gsa = 0; m_switch = 0;
        m_halted = 0; m_ovf = 0; m_unf = 0; m_target = 0; m_mem_arg = 0;
        ras_q.delete();
    endtask

    task automatic model_step();
        logic acc, nh;
        logic [4:0] op;
        logic [15:0] immv, fa, ret;
        acc = in_valid && !m_halted;
        nh = m_halted && !resume;
        m_redirect = 0; m_push = 0; m_pop = 0; m_gsa = 0; m_switch = 0;
        if (clr_fault) begin m_ovf = 0; m_unf = 0; end
        if (acc) begin
            op = instr[28:24];
            immv = imm[15:0];
            fa = f_reg[15:0];
            case (op)
                5'd1:  begin m_redirect = 1; m_target = fa; end
                5'd9:  begin m_redirect = 1; m_target = immv; end
                5'd10: begin m_redirect = 1; m_target = pc + immv; end
                5'd11: begin m_redirect = 1; m_target = pc - immv; end
                5'd5:  if (t_reg != 0) begin m_redirect = 1; m_target = fa; end
                5'd13: if (t_reg != 0) begin m_redirect = 1; m_target = immv; end
                5'd14: if (t_reg != 0) begin m_redirect = 1; m_target = pc + immv; end
                5'd15: if (t_reg != 0) begin m_redirect = 1; m_target = pc - immv; end
                5'd16, 5'd17: begin
                    m_redirect = 1;
                    m_target = (op == 5'd16) ? fa : immv;
                    if (RAS_EN) begin
                        if (ras_q.size() == D) begin void'(ras_q.pop_front()); m_ovf = 1; end
                        ret = pc + 16'd1;
                        ras_q.push_back(ret);
                    end
                end
                5'd18: begin
                    m_redirect = 1;
                    if (RAS_EN && ras_q.size() > 0) m_target = ras_q.pop_back();
                    else begin m_target = fa; if (RAS_EN) m_unf = 1; end
                end
                5'd24: begin m_redirect = 1; m_target = pc; nh = 1; end
                5'd25: begin m_push = 1; m_mem_arg = f_reg; end
                5'd26: begin m_pop = 1; m_mem_arg = {24'd0, instr[23:16]}; end
                5'd27: begin m_gsa = 1; m_mem_arg = {24'd0, instr[23:16]}; end
                5'd28: begin m_switch = 1; m_mem_arg = {8'd0, imm}; end
                default: ;
            endcase
        end
        m_halted = nh;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] f,
                         input logic [31:0] t, input logic [23:0] im, input logic [15:0] p,
                         input logic res, input logic clr);
        in_valid = v; instr = ins; f_reg = f; t_reg = t; imm = im; pc = p;
        resume = res; clr_fault = clr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 24'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; instr = 0; f_reg = 0; t_reg = 0; imm = 0; pc = 0;
        resume = 0; clr_fault = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (redirect !== 1'b0) begin errs++; $display("FAIL reset_redirect got=%0h exp=0", redirect); end
        vecs++; if (target !== 16'h0) begin errs++; $display("FAIL reset_target got=%0h exp=0", target); end
        vecs++; if ({push_o, pop_o, gsa_o, switch_o} !== 4'b0) begin errs++; $display("FAIL reset_strobes got=%0b exp=0", {push_o, pop_o, gsa_o, switch_o}); end
        vecs++; if (mem_arg !== 32'h0) begin errs++; $display("FAIL reset_mem_arg got=%0h exp=0", mem_arg); end
        vecs++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL reset_halt got=%0b/%0b exp=0/1", halted, in_ready); end
        vecs++; if ({ras_ovf, ras_unf} !== 2'b0 || ras_level !== 4'd0) begin errs++; $display("FAIL reset_ras got=%0b%0b lvl=%0d exp=00 lvl=0", ras_ovf, ras_unf, ras_level); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_jump();
        drive(1'b1, mk(5'd9, 8'h00), 32'h0, 32'h0, 24'h001234, 16'h0, 1'b0, 1'b0);
        vecs++; if (redirect !== 1'b1 || target !== 16'h1234) begin errs++; $display("FAIL jmpi got=%0b/%0h exp=1/1234", redirect, target); end
        idle();
        vecs++; if (redirect !== 1'b0 || target !== 16'h1234) begin errs++; $display("FAIL jmpi_oneshot got=%0b/%0h exp=0/1234", redirect, target); end
    endtask

    task automatic test_wrap();
        drive(1'b1, mk(5'd11, 8'h00), 32'h0, 32'h0, 24'h000020, 16'h0010, 1'b0, 1'b0);
        vecs++; if (redirect !== 1'b1 || target !== 16'hFFF0) begin errs++; $display("FAIL jmpbi_wrap got=%0b/%0h exp=1/fff0", redirect, target); end
        drive(1'b1, mk(5'd14, 8'h00), 32'h0, 32'h0, 24'h000004, 16'h0100, 1'b0, 1'b0);
        vecs++; if (redirect !== 1'b0 || target !== 16'hFFF0) begin errs++; $display("FAIL jmpcfi_nottaken got=%0b/%0h exp=0/fff0", redirect, target); end
        drive(1'b1, mk(5'd14, 8'h00), 32'h0, 32'h8000_0000, 24'h000004, 16'h0100, 1'b0, 1'b0);
        vecs++; if (redirect !== 1'b1 || target !== 16'h0104) begin errs++; $display("FAIL jmpcfi_taken got=%0b/%0h exp=1/104", redirect, target); end
    endtask

    task automatic test_call_ret();
        logic [15:0] exp_t;
        drive(1'b1, mk(5'd17, 8'h00), 32'h0, 32'h0, 24'h000100, 16'h0040, 1'b0, 1'b0);
        vecs++; if (redirect !== 1'b1 || target !== 16'h0100 || ras_level !== (RAS_EN ? 4'd1 : 4'd0)) begin
            errs++; $display("FAIL calli got=%0b/%0h lvl=%0d exp=1/100 lvl=%0d", redirect, target, ras_level, RAS_EN ? 1 : 0); end
        drive(1'b1, mk(5'd18, 8'h00), 32'h0000_7777, 32'h0, 24'h0, 16'h0100, 1'b0, 1'b0);
        exp_t = RAS_EN ? 16'h0041 : 16'h7777;
        vecs++; if (redirect !== 1'b1 || target !== exp_t || ras_level !== 4'd0) begin
            errs++; $display("FAIL ret got=%0b/%0h lvl=%0d exp=1/%0h lvl=0", redirect, target, ras_level, exp_t); end
    endtask

    task automatic test_ras_overflow();
        for (int i = 0; i <= D; i++) begin
            drive(1'b1, mk(5'd16, 8'h00), 32'h1000 + i, 32'h0, 24'h0, 16'h0300 + 16'(i), 1'b0, 1'b0);
            vecs++; if (target !== m_target || ras_level !== 4'(ras_q.size())) begin
                errs++; $display("FAIL ovf_call%0d got=%0h lvl=%0d exp=%0h lvl=%0d", i, target, ras_level, m_target, ras_q.size()); end
        end
        vecs++; if (ras_ovf !== RAS_EN || ras_unf !== 1'b0) begin errs++; $display("FAIL ovf_flag got=%0b%0b exp=%0b0", ras_ovf, ras_unf, RAS_EN); end
        for (int i = 0; i <= D; i++) begin
            drive(1'b1, mk(5'd18, 8'h00), 32'h0000_ABCD, 32'h0, 24'h0, 16'h0500, 1'b0, 1'b0);
            vecs++; if (redirect !== 1'b1 || target !== m_target || ras_level !== 4'(ras_q.size())) begin
                errs++; $display("FAIL ovf_ret%0d got=%0h lvl=%0d exp=%0h lvl=%0d", i, target, ras_level, m_target, ras_q.size()); end
        end
        vecs++; if (target !== 16'hABCD || ras_unf !== RAS_EN || ras_ovf !== RAS_EN) begin
            errs++; $display("FAIL unf_flag got=%0h %0b%0b exp=abcd %0b%0b", target, ras_ovf, ras_unf, RAS_EN, RAS_EN); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 24'd0, 16'd0, 1'b0, 1'b1);
        vecs++; if ({ras_ovf, ras_unf} !== 2'b00) begin errs++; $display("FAIL clr_fault got=%0b%0b exp=00", ras_ovf, ras_unf); end
    endtask

    task automatic test_halt();
        drive(1'b1, mk(5'd24, 8'h00), 32'h0, 32'h0, 24'h0, 16'h0200, 1'b0, 1'b0);
        vecs++; if (redirect !== 1'b1 || target !== 16'h0200 || halted !== 1'b1 || in_ready !== 1'b0) begin
            errs++; $display("FAIL halt got=%0b/%0h h=%0b r=%0b exp=1/200 h=1 r=0", redirect, target, halted, in_ready); end
        drive(1'b1, mk(5'd9, 8'h00), 32'h0, 32'h0, 24'h000055, 16'h0201, 1'b0, 1'b0);
        vecs++; if (redirect !== 1'b0 || target !== 16'h0200 || halted !== 1'b1) begin
            errs++; $display("FAIL halt_ignore got=%0b/%0h h=%0b exp=0/200 h=1", redirect, target, halted); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 24'd0, 16'd0, 1'b1, 1'b0);
        vecs++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL resume got h=%0b r=%0b exp h=0 r=1", halted, in_ready); end
    endtask

    task automatic test_memops();
        drive(1'b1, mk(5'd25, 8'h00), 32'hDEADBEEF, 32'h0, 24'h0, 16'h0, 1'b0, 1'b0);
        vecs++; if (push_o !== 1'b1 || mem_arg !== 32'hDEADBEEF || redirect !== 1'b0) begin
            errs++; $display("FAIL push got=%0b/%0h exp=1/deadbeef", push_o, mem_arg); end
        drive(1'b1, mk(5'd26, 8'hA5), 32'h0, 32'h0, 24'h0, 16'h0, 1'b0, 1'b0);
        vecs++; if (pop_o !== 1'b1 || push_o !== 1'b0 || mem_arg !== 32'h0000_00A5) begin
            errs++; $display("FAIL pop got=%0b/%0h exp=1/a5", pop_o, mem_arg); end
        drive(1'b1, mk(5'd28, 8'h00), 32'h0, 32'h0, 24'hC0FFEE, 16'h0, 1'b0, 1'b0);
        vecs++; if (switch_o !== 1'b1 || mem_arg !== 32'h00C0FFEE) begin
            errs++; $display("FAIL switch got=%0b/%0h exp=1/c0ffee", switch_o, mem_arg); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            drive(1'b1, mk(5'd17, 8'h00), 32'h0, 32'h0, 24'h000700 + 24'(i), 16'h0600 + 16'(i), 1'b0, 1'b0);
        #1 rst_n = 0;
        #1;
        vecs++; if (redirect !== 1'b0 || target !== 16'h0 || ras_level !== 4'd0 || mem_arg !== 32'h0 || in_ready !== 1'b1) begin
            errs++; $display("FAIL reset_mid got=%0b/%0h lvl=%0d arg=%0h r=%0b exp=0/0 lvl=0 arg=0 r=1", redirect, target, ras_level, mem_arg, in_ready); end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        drive(1'b1, mk(5'd18, 8'h00), 32'h0000_4242, 32'h0, 24'h0, 16'h0, 1'b0, 1'b0);
        vecs++; if (target !== 16'h4242 || ras_unf !== RAS_EN) begin
            errs++; $display("FAIL reset_mid_ret got=%0h unf=%0b exp=4242 unf=%0b", target, ras_unf, RAS_EN); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 24'd0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [4:0] ops[19] = '{5'd1, 5'd9, 5'd10, 5'd11, 5'd5, 5'd13, 5'd14, 5'd15, 5'd16,
                                5'd17, 5'd18, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd0, 5'd3, 5'd31};
        logic [31:0] ins;
        for (int c = 0; c < 400; c++) begin
            ins = $urandom;
            ins[28:24] = ops[$urandom_range(18)];
            drive(($urandom_range(3) != 0), ins, $urandom, ($urandom_range(1) == 0) ? 32'd0 : $urandom,
                  24'($urandom), 16'($urandom), ($urandom_range(2) == 0), ($urandom_range(7) == 0));
            vecs++; if (redirect !== m_redirect || target !== m_target) begin
                errs++; $display("FAIL rnd%0d redir got=%0b/%0h exp=%0b/%0h", c, redirect, target, m_redirect, m_target); end
            vecs++; if ({push_o, pop_o, gsa_o, switch_o} !== {m_push, m_pop, m_gsa, m_switch} || mem_arg !== m_mem_arg) begin
                errs++; $display("FAIL rnd%0d mem got=%0b/%0h exp=%0b/%0h", c, {push_o, pop_o, gsa_o, switch_o}, mem_arg,
                                 {m_push, m_pop, m_gsa, m_switch}, m_mem_arg); end
            vecs++; if (halted !== m_halted || in_ready !== !m_halted) begin
                errs++; $display("FAIL rnd%0d halt got=%0b/%0b exp=%0b/%0b", c, halted, in_ready, m_halted, !m_halted); end
            vecs++; if (ras_level !== 4'(ras_q.size()) || ras_ovf !== m_ovf || ras_unf !== m_unf) begin
                errs++; $display("FAIL rnd%0d ras got=%0d %0b%0b exp=%0d %0b%0b", c, ras_level, ras_ovf, ras_unf,
                                 ras_q.size(), m_ovf, m_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_wrap();
        test_call_ret();
        test_ras_overflow();
        test_halt();
        test_memops();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
